// File: rtl/ym3438_host_pkg.sv
// Shared constants for the YM3438 host register writer: FSM encodings,
// bus address selects, status busy bit and the phase-timer width helper.
package ym3438_host_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_A_SETUP = 4'd1;
    localparam logic [STATE_W-1:0] ST_A_PULSE = 4'd2;
    localparam logic [STATE_W-1:0] ST_A_HOLD  = 4'd3;
    localparam logic [STATE_W-1:0] ST_A_GAP   = 4'd4;
    localparam logic [STATE_W-1:0] ST_D_SETUP = 4'd5;
    localparam logic [STATE_W-1:0] ST_D_PULSE = 4'd6;
    localparam logic [STATE_W-1:0] ST_D_HOLD  = 4'd7;
    localparam logic [STATE_W-1:0] ST_WAIT    = 4'd8;
    localparam logic [STATE_W-1:0] ST_P_GAP   = 4'd9;
    localparam logic [STATE_W-1:0] ST_P_SETUP = 4'd10;
    localparam logic [STATE_W-1:0] ST_P_PULSE = 4'd11;
    localparam logic [STATE_W-1:0] ST_P_HOLD  = 4'd12;

    // A0 selects address (0) or data (1); status reads use A1:A0 = 00
    localparam logic       A0_ADDR  = 1'b0;
    localparam logic       A0_DATA  = 1'b1;
    localparam logic [1:0] A_STATUS = 2'b00;

    localparam int BUSY_BIT = 7;

    // Timer holds at most max(N)-1, so clog2 of the largest phase suffices
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ym3438_host_timer.sv
// Loadable down-counter used to time each bus phase; zero flags phase end.
module ym3438_host_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ym3438_host_writer.sv
// YM3438 CPU-bus register writer: address write, data write, then busy wait.
// Define YM3438_HOST_BUSY_POLL_EN to replace the fixed wait with status polling.
module ym3438_host_writer
    import ym3438_host_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 4,
    parameter int HOLD_CYC      = 2,
    parameter int BUSY_WAIT_CYC = 32,
    parameter int POLL_MAX      = 16
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_port,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    output logic       bus_rd_n,
    output logic [1:0] bus_a,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    input  logic [7:0] bus_d_in,
    output logic       timeout
);

    localparam int TW = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, BUSY_WAIT_CYC);

    logic [STATE_W-1:0] state_q, state_d;
    logic               port_q, port_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               cs_n_q, cs_n_d;
    logic               wr_n_q, wr_n_d;
    logic [1:0]         a_q, a_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               timer_zero;

`ifdef YM3438_HOST_BUSY_POLL_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [STATE_W-1:0] POST_STATE = ST_P_GAP;

    logic          rd_n_q, rd_n_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] poll_q, poll_d, poll_inc;
    logic          timeout_q, timeout_d;
    logic          poll_done;
    logic          unused_d_in;

    assign unused_d_in = ^bus_d_in;

    // Busy bit is captured on the last strobe cycle and judged at end of P_HOLD
    always_comb begin
        poll_d    = poll_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        poll_done = !busy_q;
        poll_inc  = poll_q + PW'(1);
        if (state_q == ST_IDLE && req_valid) begin
            poll_d = '0;
        end
        if (state_q == ST_P_PULSE && timer_zero) begin
            busy_d = bus_d_in[BUSY_BIT];
        end
        if (state_q == ST_P_HOLD && timer_zero && busy_q) begin
            poll_d = poll_inc;
            if (poll_inc == PW'(POLL_MAX)) begin
                poll_done = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    assign rd_n_d = (state_d != ST_P_PULSE);

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            rd_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            poll_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            rd_n_q    <= rd_n_d;
            busy_q    <= busy_d;
            poll_q    <= poll_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus_rd_n = rd_n_q;
    assign timeout  = timeout_q;
`else
    localparam logic [STATE_W-1:0] POST_STATE = ST_WAIT;

    logic unused_d_in;

    assign unused_d_in = ^{bus_d_in, bus_d_in[BUSY_BIT], POLL_MAX != 0};
    assign bus_rd_n    = 1'b1;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_A_SETUP;
                    port_d  = req_port;
                    addr_d  = req_addr;
                    data_d  = req_data;
                end
            end
            ST_A_SETUP: if (timer_zero) state_d = ST_A_PULSE;
            ST_A_PULSE: if (timer_zero) state_d = ST_A_HOLD;
            ST_A_HOLD:  if (timer_zero) state_d = ST_A_GAP;
            ST_A_GAP:   state_d = ST_D_SETUP;
            ST_D_SETUP: if (timer_zero) state_d = ST_D_PULSE;
            ST_D_PULSE: if (timer_zero) state_d = ST_D_HOLD;
            ST_D_HOLD:  if (timer_zero) state_d = POST_STATE;
`ifdef YM3438_HOST_BUSY_POLL_EN
            ST_P_GAP:   state_d = ST_P_SETUP;
            ST_P_SETUP: if (timer_zero) state_d = ST_P_PULSE;
            ST_P_PULSE: if (timer_zero) state_d = ST_P_HOLD;
            ST_P_HOLD:  if (timer_zero) state_d = poll_done ? ST_IDLE : ST_P_GAP;
            ST_WAIT:    state_d = ST_IDLE;
`else
            ST_WAIT:    if (timer_zero) state_d = ST_IDLE;
            ST_P_GAP, ST_P_SETUP, ST_P_PULSE, ST_P_HOLD: state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Timer is loaded with N-1 on every state change into a timed phase
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            ST_A_SETUP, ST_D_SETUP, ST_P_SETUP: timer_val = TW'(SETUP_CYC - 1);
            ST_A_PULSE, ST_D_PULSE, ST_P_PULSE: timer_val = TW'(PULSE_CYC - 1);
            ST_A_HOLD,  ST_D_HOLD,  ST_P_HOLD:  timer_val = TW'(HOLD_CYC - 1);
            ST_WAIT:                            timer_val = TW'(BUSY_WAIT_CYC - 1);
            default:                            timer_val = '0;
        endcase
    end

    // Bus outputs are decoded from the next state so they change on entry
    always_comb begin
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        a_d     = A_STATUS;
        dout_d  = '0;
        oe_d    = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
                cs_n_d = 1'b0;
                oe_d   = 1'b1;
                a_d    = {port_d, A0_ADDR};
                dout_d = addr_d;
                wr_n_d = (state_d != ST_A_PULSE);
            end
            ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
                cs_n_d = 1'b0;
                oe_d   = 1'b1;
                a_d    = {port_d, A0_DATA};
                dout_d = data_d;
                wr_n_d = (state_d != ST_D_PULSE);
            end
            ST_P_SETUP, ST_P_PULSE, ST_P_HOLD: cs_n_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            a_q     <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
        end
    end

    ym3438_host_timer #(.W(TW)) u_timer (
        .clk      (MCLK),
        .rst      (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign req_ready = ready_q;
    assign bus_cs_n  = cs_n_q;
    assign bus_wr_n  = wr_n_q;
    assign bus_a     = a_q;
    assign bus_d_out = dout_q;
    assign bus_d_oe  = oe_q;

endmodule
